alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Three-state sequencer wrapping an external combinational ALU: captures a request,
// allows one cycle for the ALU, then holds the result until it is consumed. Optional macro: STICKY_OVF_EN.
module alu_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [2:0]   in_f,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_f,
    input  logic [N-1:0] alu_y,
    input  logic         alu_o,
    input  logic         alu_z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y,
    output logic         out_o,
    output logic         out_z,
    output logic [15:0]  op_count,
    input  logic         clr_sticky,
    output logic         ovf_sticky
);

    // state | meaning
    // IDLE  | waiting for a request; in_ready high
    // EXEC  | operands on alu_*; result captured at the closing edge
    // DONE  | result held on out_*; out_valid high until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [N-1:0]  alu_a_q;
    logic [N-1:0]  alu_b_q;
    logic [2:0]    alu_f_q;
    logic [N-1:0]  out_y_q;
    logic          out_o_q;
    logic          out_z_q;
    logic [15:0]   op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= 3'b000;
            out_y_q     <= '0;
            out_o_q     <= 1'b0;
            out_z_q     <= 1'b0;
            op_count_q  <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        alu_a_q    <= in_a;
                        alu_b_q    <= in_b;
                        alu_f_q    <= in_f;
                        in_ready_q <= 1'b0;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    out_y_q     <= alu_y;
                    out_o_q     <= alu_o;
                    out_z_q     <= alu_z;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_f     = alu_f_q;
    assign out_y     = out_y_q;
    assign out_o     = out_o_q;
    assign out_z     = out_z_q;
    assign op_count  = op_count_q;

`ifdef STICKY_OVF_EN
    logic ovf_sticky_q;
    logic ovf_sticky_d;

    // A capture of overflow takes priority over a simultaneous clear.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (clr_sticky) ovf_sticky_d = 1'b0;
        if (state_q == EXEC && alu_o) ovf_sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_sticky_q <= 1'b0;
        else        ovf_sticky_q <= ovf_sticky_d;
    end

    assign ovf_sticky = ovf_sticky_q;
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign ovf_sticky        = 1'b0;
`endif

endmodule
